seq_divider: RTL and testbench

- Iterative radix-2 restoring unsigned divider; the inverse companion to the team's 16x16 Vedic multiplier.
- Accepts a 2N-bit dividend, such as a multiplier product, and an N-bit divisor.
- Produces a 2N-bit quotient and an N-bit remainder over 2N clock cycles.
- Uses a start/busy/done handshake and sits beside the multiplier in the arithmetic datapath.

---
 rtl/seq_divider_if.sv | 23 ++
 rtl/seq_divider.sv | 122 ++++++++++++
 tb/tb_seq_divider.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// The master drives operands and start; the slave returns status and results.
`timescale 1ns/1ps
interface seq_divider_if #(parameter int N = 16);
    logic             start;
    logic [2*N-1:0]   Dividend;
    logic [N-1:0]     Divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [2*N-1:0]   Quotient;
    logic [N-1:0]     Remainder;

    modport master (
        output start, Dividend, Divisor,
        input  busy, done, div_by_zero, Quotient, Remainder
    );

    modport slave (
        input  start, Dividend, Divisor,
        output busy, done, div_by_zero, Quotient, Remainder
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring unsigned divider: 2N-bit dividend / N-bit divisor in 2N cycles.
// Results are held in output registers from done until the next accepted start.
`timescale 1ns/1ps
module seq_divider #(
    parameter int N = 16
) (
    input  logic        clk,
    input  logic        rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(2*N+1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;
    logic [2*N-1:0]  quot_out_q, quot_out_d;
    logic [N-1:0]    rem_out_q, rem_out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    divisor_q, divisor_d;
    logic [2*N-1:0]  qreg_q, qreg_d;
    logic [N-1:0]    prem_q, prem_d;

    // After a restore the partial remainder is always below the divisor, so
    // only the shifted value needs the extra (N+1)th bit.
    logic [N:0]      shifted;
    logic            fits;
    logic [N-1:0]    trial;
    logic [N-1:0]    prem_next;
    logic [2*N-1:0]  qreg_next;

    assign shifted   = {prem_q, qreg_q[2*N-1]};
    assign fits      = shifted >= {1'b0, divisor_q};
    assign trial     = shifted[N-1:0] - divisor_q;
    assign prem_next = fits ? trial : shifted[N-1:0];
    assign qreg_next = {qreg_q[2*N-2:0], fits};

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        cnt_d      = cnt_q;
        divisor_d  = divisor_q;
        qreg_d     = qreg_q;
        prem_d     = prem_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.Divisor != '0) begin
                        state_d   = RUN;
                        busy_d    = 1'b1;
                        dbz_d     = 1'b0;
                        divisor_d = bus.Divisor;
                        qreg_d    = bus.Dividend;
                        prem_d    = '0;
                        cnt_d     = CW'(2*N);
                    end else begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        dbz_d      = 1'b1;
                        quot_out_d = '1;
                        rem_out_d  = '0;
                    end
                end
            end
            RUN: begin
                qreg_d = qreg_next;
                prem_d = prem_next;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    quot_out_d = qreg_next;
                    rem_out_d  = prem_next;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            cnt_q      <= '0;
            divisor_q  <= '0;
            qreg_q     <= '0;
            prem_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
            cnt_q      <= cnt_d;
            divisor_q  <= divisor_d;
            qreg_q     <= qreg_d;
            prem_q     <= prem_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.Quotient    = quot_out_q;
    assign bus.Remainder   = rem_out_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases, handshake timing
// and randomized multiplier-product cross-checks against plain / and % arithmetic.
`timescale 1ns/1ps
module tb_seq_divider;
    localparam int N = 16;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents operands with start for one accepting edge, then scrambles the
    // inputs so any late sampling of them corrupts the result.
    task automatic start_op(input logic [2*N-1:0] a, input logic [N-1:0] b);
        bus.Dividend = a;
        bus.Divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.Dividend = $urandom;
        bus.Divisor  = N'($urandom);
    endtask

    // Counts edges after the accepting edge until done, bounded to 100.
    task automatic wait_done(output int lat, output int busy_cnt, output bit stable);
        logic [2*N-1:0] q0;
        logic [N-1:0]   r0;
        q0       = bus.Quotient;
        r0       = bus.Remainder;
        lat      = 0;
        stable   = 1'b1;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (!bus.done && (bus.Quotient !== q0 || bus.Remainder !== r0)) stable = 1'b0;
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic run_case(input string tag, input logic [2*N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] exp_q;
        logic [N-1:0]   exp_r;
        int             exp_lat;
        int             lat, busy_cnt;
        bit             stable;
        if (b == 0) begin
            exp_q   = '1;
            exp_r   = '0;
            exp_lat = 0;
        end else begin
            exp_q   = a / {{N{1'b0}}, b};
            exp_r   = N'(a % {{N{1'b0}}, b});
            exp_lat = 2*N;
        end
        start_op(a, b);
        wait_done(lat, busy_cnt, stable);
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        check({tag, ".out_stable"}, 64'(stable), 64'd1);
        check({tag, ".quotient"}, 64'(bus.Quotient), 64'(exp_q));
        check({tag, ".remainder"}, 64'(bus.Remainder), 64'(exp_r));
        check({tag, ".div_by_zero"}, 64'(bus.div_by_zero), 64'(b == 0));
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int first_done, n_done, lat, busy_cnt;
        bit stable;
        logic [N-1:0]   ra, rb, rr;
        logic [2*N-1:0] prod;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.Dividend = '0;
        bus.Divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.dbz", 64'(bus.div_by_zero), 64'd0);
        check("reset.q", 64'(bus.Quotient), 64'd0);
        check("reset.r", 64'(bus.Remainder), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_case("d100_7", 32'd100, 16'd7);
        run_case("max_max", 32'hFFFF_FFFF, 16'hFFFF);
        run_case("max_1", 32'hFFFF_FFFF, 16'd1);
        run_case("zero_dividend", 32'd0, 16'd9);
        run_case("small_by_big", 32'd5, 16'hFFFF);

        run_case("div0", 32'h1234, 16'd0);
        repeat (5) @(posedge clk);
        #1;
        check("div0.dbz_held", 64'(bus.div_by_zero), 64'd1);
        check("div0.q_held", 64'(bus.Quotient), 64'hFFFF_FFFF);
        run_case("after_div0", 32'd1000, 16'd10);

        // start pulses during RUN (edge k+5) and during DONE (edge k+33) are ignored
        start_op(32'd100, 16'd7);
        first_done = -1;
        n_done     = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                bus.start = 1'b1; bus.Dividend = 32'd500; bus.Divisor = 16'd3;
            end
            if (i == 33) begin
                bus.start = 1'b1; bus.Dividend = 32'd77; bus.Divisor = 16'd0;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin
                if (first_done < 0) first_done = i;
                n_done++;
            end
        end
        check("ignore.first_done", 64'(first_done), 64'd32);
        check("ignore.done_count", 64'(n_done), 64'd1);
        check("ignore.q", 64'(bus.Quotient), 64'd14);
        check("ignore.r", 64'(bus.Remainder), 64'd2);
        check("ignore.dbz", 64'(bus.div_by_zero), 64'd0);

        // asynchronous reset in the middle of a run
        start_op(32'd1000, 16'd3);
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst.busy", 64'(bus.busy), 64'd0);
        check("midrst.done", 64'(bus.done), 64'd0);
        check("midrst.q", 64'(bus.Quotient), 64'd0);
        check("midrst.r", 64'(bus.Remainder), 64'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) n_done++;
        end
        check("midrst.no_done", 64'(n_done), 64'd0);
        run_case("after_rst", 32'd50, 16'd5);

        // multiplier product cross-check: (A*B + r) / B must give A rem r
        for (int i = 0; i < 1000; i++) begin
            ra   = N'($urandom);
            rb   = N'($urandom_range(65535, 1));
            rr   = N'($urandom_range(32'(rb) - 1, 0));
            prod = 32'(ra) * 32'(rb) + 32'(rr);
            start_op(prod, rb);
            wait_done(lat, busy_cnt, stable);
            check("mul.latency", 64'(lat), 64'd32);
            check("mul.quotient", 64'(bus.Quotient), 64'(ra));
            check("mul.remainder", 64'(bus.Remainder), 64'(rr));
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
